// File: rtl/shift_sequencer.sv
// Control stage for an external 8-bit load/rotate/arithmetic-shift register: runs exactly N steps per command.
// Define PRESCALE_EN to space steps DIV clocks apart (visible stepping on board LEDs).
//
// state    | meaning
// ST_IDLE  | register held by reloading shadow; waiting for start
// ST_SYNC  | one cycle; register loads the freshly latched shadow
// ST_SHIFT | step on tick, reload shadow (hold) otherwise
// ST_DONE  | one-cycle done pulse, then back to idle
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int DIV   = 50000000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             dir_right,
    input  logic             arith,
    input  logic [CNT_W-1:0] count,
    output logic             ParallelLoadn,
    output logic             RotateRight,
    output logic             ASRight,
    output logic [WIDTH-1:0] Data_OUT,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shadow_q
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SYNC  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] shadow;
    logic [WIDTH-1:0] shadow_nxt;
    logic [WIDTH-1:0] shadow_step;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             dir_q;
    logic             arith_q;
    logic             tick;
    logic             step;
    logic             accept;

    generate
        if (DIV < 1) begin : g_div_check
            $error("shift_sequencer: DIV must be at least 1");
        end
    endgenerate

`ifdef PRESCALE_EN
    localparam int              PS_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(DIV - 1);

    logic [PS_W-1:0] ps_cnt;

    // Held at zero outside SHIFT so the first step lands DIV cycles after entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ps_cnt <= '0;
        end else if (state != ST_SHIFT) begin
            ps_cnt <= '0;
        end else if (ps_cnt == PS_LAST) begin
            ps_cnt <= '0;
        end else begin
            ps_cnt <= ps_cnt + PS_W'(1);
        end
    end

    assign tick = (ps_cnt == PS_LAST);
`else
    assign tick = 1'b1;
`endif

    assign step   = (state == ST_SHIFT) && tick;
    assign accept = (state == ST_IDLE) && start;

    // Mirrors what the external register does when ParallelLoadn is high.
    always_comb begin
        if (!dir_q) begin
            shadow_step = {shadow[WIDTH-2:0], shadow[WIDTH-1]};
        end else if (arith_q) begin
            shadow_step = {shadow[WIDTH-1], shadow[WIDTH-1:1]};
        end else begin
            shadow_step = {shadow[0], shadow[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_nxt  = state;
        shadow_nxt = shadow;
        cnt_nxt    = cnt;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt  = ST_SYNC;
                    shadow_nxt = din;
                    cnt_nxt    = count;
                end
            end
            ST_SYNC: begin
                state_nxt = (cnt != '0) ? ST_SHIFT : ST_DONE;
            end
            ST_SHIFT: begin
                if (tick) begin
                    shadow_nxt = shadow_step;
                    cnt_nxt    = (cnt != '0) ? cnt - CNT_W'(1) : '0;
                    if (cnt <= CNT_W'(1)) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            shadow <= '0;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            shadow <= shadow_nxt;
            cnt    <= cnt_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
        end else if (accept) begin
            dir_q   <= dir_right;
            arith_q <= arith;
        end
    end

    // The register has no enable: every non-step cycle reloads the shadow so Q holds.
    assign ParallelLoadn = step;
    assign RotateRight   = (state != ST_IDLE) && dir_q;
    assign ASRight       = (state != ST_IDLE) && dir_q && arith_q;
    assign Data_OUT      = shadow;
    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_DONE);
    assign shadow_q      = shadow;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: models the external register and predicts results arithmetically.
// Build with PRESCALE_EN defined to exercise the prescaled stepping with DIV=4.
`timescale 1ns/1ps
module tb_shift_sequencer;

    localparam int W  = 8;
    localparam int CW = 4;
`ifdef PRESCALE_EN
    localparam int DIV_TB = 4;
`else
    localparam int DIV_TB = 1;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  din = '0;
    logic          dir_right = 1'b0;
    logic          arith = 1'b0;
    logic [CW-1:0] count = '0;
    logic          ParallelLoadn;
    logic          RotateRight;
    logic          ASRight;
    logic [W-1:0]  Data_OUT;
    logic          busy;
    logic          done;
    logic [W-1:0]  shadow_q;

    logic [W-1:0]  reg_q;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;

    typedef struct {
        logic [W-1:0] q;
        int           done_cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    shift_sequencer #(.WIDTH(W), .CNT_W(CW), .DIV(DIV_TB)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .din(din),
        .dir_right(dir_right),
        .arith(arith),
        .count(count),
        .ParallelLoadn(ParallelLoadn),
        .RotateRight(RotateRight),
        .ASRight(ASRight),
        .Data_OUT(Data_OUT),
        .busy(busy),
        .done(done),
        .shadow_q(shadow_q)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // The physical register: parallel load when ParallelLoadn is low, otherwise one shift.
    always @(posedge clock) begin
        if (!ParallelLoadn)     reg_q <= Data_OUT;
        else if (!RotateRight)  reg_q <= {reg_q[W-2:0], reg_q[W-1]};
        else if (ASRight)       reg_q <= {reg_q[W-1], reg_q[W-1:1]};
        else                    reg_q <= {reg_q[0], reg_q[W-1:1]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Result of n steps computed as a rotate-by-(n mod W) or a signed shift.
    function automatic logic [W-1:0] ref_result(input logic [W-1:0] d, input logic dr,
                                                input logic ar, input int n);
        int unsigned          x;
        int unsigned          k;
        int unsigned          mask;
        logic signed [W-1:0]  s;
        x    = 32'(d);
        mask = (32'd1 << W) - 32'd1;
        k    = 32'(n % W);
        if (dr && ar) begin
            s = d;
            s = s >>> n;
            return s;
        end
        if (dr) return W'(((x >> k) | (x << (W - k))) & mask);
        return W'(((x << k) | (x >> (W - k))) & mask);
    endfunction

    task automatic push_exp(input logic [W-1:0] d, input logic dr, input logic ar,
                            input int n, input int c0);
        exp_t e;
        e.q        = ref_result(d, dr, ar, n);
        e.done_cyc = c0 + 1 + n * DIV_TB;
        sb_q.push_back(e);
    endtask

    always @(negedge clock) begin
        if (!reset && done) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pulse", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("done_cycle", cyc, mon_e.done_cyc);
                check("done_shadow_q", 32'(shadow_q), 32'(mon_e.q));
                check("done_reg_q", 32'(reg_q), 32'(mon_e.q));
            end
        end
    end

    task automatic wait_not_busy();
        int t;
        t = 0;
        @(negedge clock);
        while (busy && t < 2000) begin
            @(negedge clock);
            t++;
        end
        if (busy) begin
            n_checks++;
            $display("FAIL idle_timeout: got busy=1 after 2000 cycles, required 0");
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb_q.size() != 0 || busy) && t < 5000) begin
            @(negedge clock);
            t++;
        end
        if (sb_q.size() != 0 || busy) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d outstanding done pulses, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic issue(input logic [W-1:0] d, input logic dr, input logic ar,
                         input logic [CW-1:0] n, output int c0);
        wait_not_busy();
        din       = d;
        dir_right = dr;
        arith     = ar;
        count     = n;
        start     = 1'b1;
        @(posedge clock);
        #1;
        c0 = cyc;
        push_exp(d, dr, ar, int'(n), c0);
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic run_known(input logic [W-1:0] d, input logic dr, input logic ar,
                             input logic [CW-1:0] n, input logic [W-1:0] known, input string name);
        int c0;
        issue(d, dr, ar, n, c0);
        drain();
        check(name, 32'(shadow_q), 32'(known));
        check({name, "_reg"}, 32'(reg_q), 32'(known));
    endtask

    initial begin
        int c0;
        int c1;
        int bad;

        repeat (3) @(negedge clock);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ploadn", 32'(ParallelLoadn), 32'd0);
        check("rst_data_out", 32'(Data_OUT), 32'd0);
        check("rst_shadow", 32'(shadow_q), 32'd0);
        check("rst_rotright", 32'(RotateRight), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("reg_after_reset", 32'(reg_q), 32'd0);

        run_known(8'b1000_0001, 1'b1, 1'b0, 4'd3, 8'b0011_0000, "rot_right3");
        run_known(8'b1000_0000, 1'b1, 1'b1, 4'd3, 8'b1111_0000, "asr_neg3");
        run_known(8'b0100_0000, 1'b1, 1'b1, 4'd3, 8'b0000_1000, "asr_pos3");
        run_known(8'b1000_0001, 1'b0, 1'b1, 4'd1, 8'b0000_0011, "rot_left1");
        run_known(8'hC6,        1'b0, 1'b0, 4'd8, 8'hC6,        "rot_left8");
        run_known(8'h96,        1'b1, 1'b1, 4'd15, 8'hFF,       "asr_max");
        run_known(8'h01,        1'b1, 1'b0, 4'd15, 8'h02,       "rot_right_max");

        run_known(8'hA5, 1'b1, 1'b0, 4'd0, 8'hA5, "zero_count");
        bad = 0;
        repeat (20) begin
            @(negedge clock);
            if (reg_q !== 8'hA5 || shadow_q !== 8'hA5 || busy !== 1'b0) bad++;
        end
        check("idle_hold_bad_cycles", 32'(bad), 32'd0);

        issue(8'h3C, 1'b1, 1'b0, 4'd10, c0);
        repeat (3) @(negedge clock);
        din = 8'hFF; dir_right = 1'b0; count = 4'd1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        drain();
        check("ignored_start_result", 32'(shadow_q), 32'h0F);

        wait_not_busy();
        din = 8'h81; dir_right = 1'b1; arith = 1'b0; count = 4'd3; start = 1'b1;
        @(posedge clock);
        #1;
        c0 = cyc;
        push_exp(8'h81, 1'b1, 1'b0, 3, c0);
        c1 = c0 + 3 + 3 * DIV_TB;
        push_exp(8'h81, 1'b1, 1'b0, 3, c1);
        while (cyc < c1) @(negedge clock);
        start = 1'b0;
        drain();

        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), 1'($urandom), 1'($urandom), CW'($urandom_range(0, 15)), c0);
        end
        drain();

        issue(8'hFF, 1'b1, 1'b0, 4'd6, c0);
        while (cyc < c0 + 1 + 2 * DIV_TB) @(negedge clock);
        reset = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_shadow", 32'(shadow_q), 32'd0);
        sb_q.delete();
        repeat (2) @(negedge clock);
        check("midrst_done_held", 32'(done), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("midrst_reg_after_release", 32'(reg_q), 32'd0);
        repeat (5) @(negedge clock);
        check("midrst_stays_idle", 32'(busy), 32'd0);

        run_known(8'h12, 1'b0, 1'b0, 4'd4, 8'h21, "post_reset_cmd");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
